// File: rtl/uart_pkg.sv
// Shared UART constants and state types for the 128-bit transmit path.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_FRAME_BITS           = 10;
    localparam int UART_WORD_BYTES           = 16;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_WORD_BITS            = UART_DATA_BITS * UART_WORD_BYTES;

    // Single-frame transmitter states.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Word sequencer states. Load, next-byte and done are actions taken on
    // the edges that enter or leave TOP_SEND, so they never occupy a cycle.
    typedef enum logic {
        TOP_IDLE,
        TOP_SEND
    } top_state_e;

    // Width of a counter that must hold 0..cpb-1 (at least one bit).
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame transmitter. tx_done is high during the last cycle of the
// stop bit so a caller can chain the next frame on the very same edge.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_start,
    input  logic [UART_DATA_BITS-1:0] tx_byte,
    output logic                      u_tx,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      u_tx_q, u_tx_d;

    logic bit_end;
    logic load;

    assign bit_end = (cnt_q == CNT_MAX);
    // A new byte is taken when idle or exactly as the stop bit ends.
    assign load    = tx_start && ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end));

    // State and datapath registers; the line output is registered so it is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            u_tx_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            u_tx_q    <= u_tx_d;
        end
    end

    // Next-state logic: start bit, eight data bits, stop bit, optionally straight into another frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (tx_start) state_d = TX_START;
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA:  if (bit_end && (bit_idx_q == LAST_BIT)) state_d = TX_STOP;
            TX_STOP:  if (bit_end) state_d = tx_start ? TX_START : TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Bit timer, bit index and data shifter; the bit on the wire is always shift[0].
    always_comb begin
        cnt_d     = ((state_q == TX_IDLE) || bit_end) ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (load) begin
            shift_d   = tx_byte;
            bit_idx_d = '0;
        end else if ((state_q == TX_DATA) && bit_end) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
        end
    end

    // Outputs: line level for the coming cycle plus status flags.
    always_comb begin
        case (state_d)
            TX_START: u_tx_d = 1'b0;
            TX_DATA:  u_tx_d = shift_d[0];
            default:  u_tx_d = 1'b1;
        endcase
        tx_busy = (state_q != TX_IDLE);
        tx_done = (state_q == TX_STOP) && bit_end;
    end

    assign u_tx = u_tx_q;

endmodule

// File: rtl/uart_tx_128.sv
// 128-bit word transmitter: sends 16 back-to-back 8N1 frames, MSB byte first.
module uart_tx_128
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_WORD_BITS-1:0] data_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      u_tx,
    output logic                      u_byte_done,
    output logic                      u_tx_done
);

    localparam logic [3:0] LAST_BYTE = 4'(UART_WORD_BYTES - 1);

    top_state_e                state_q, state_d;
    logic [UART_WORD_BITS-1:0] shift_q, shift_d;
    logic [3:0]                byte_cnt_q, byte_cnt_d;
    logic                      byte_done_q, byte_done_d;
    logic                      tx_done_q, tx_done_d;

    logic                      tx_start;
    logic [UART_DATA_BITS-1:0] tx_byte;
    logic                      tx_busy;
    logic                      frame_end;
    logic                      accept;
    logic                      last_byte;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .u_tx    (u_tx),
        .tx_busy (tx_busy),
        .tx_done (frame_end)
    );

    // The transmitter idle check keeps a request from ever landing mid-frame.
    assign accept    = (state_q == TOP_IDLE) && start && !tx_busy;
    assign last_byte = (byte_cnt_q == LAST_BYTE);

    // State, word shifter, byte counter and the registered done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TOP_IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            byte_done_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_done_q <= byte_done_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Next-state logic: stay in SEND until the 16th frame's stop bit ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TOP_IDLE: if (accept) state_d = TOP_SEND;
            TOP_SEND: if (frame_end && last_byte) state_d = TOP_IDLE;
            default:  state_d = TOP_IDLE;
        endcase
    end

    // Load on accept, shift left a byte after each frame and hand the new top byte straight on.
    always_comb begin
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        tx_start    = 1'b0;
        byte_done_d = 1'b0;
        tx_done_d   = 1'b0;
        if (accept) begin
            shift_d    = data_in;
            byte_cnt_d = '0;
            tx_start   = 1'b1;
        end else if ((state_q == TOP_SEND) && frame_end) begin
            shift_d     = shift_q << UART_DATA_BITS;
            byte_done_d = 1'b1;
            if (last_byte) begin
                byte_cnt_d = '0;
                tx_done_d  = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
                tx_start   = 1'b1;
            end
        end
        tx_byte = shift_d[UART_WORD_BITS-1 -: UART_DATA_BITS];
    end

    assign busy        = (state_q == TOP_SEND);
    assign u_byte_done = byte_done_q;
    assign u_tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_128.sv
// Randomised scoreboard bench for uart_tx_128 with a serial-line decoder and loopback receiver model.
module tb_uart_tx_128;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int XFER  = 160 * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic         busy;
    logic         u_tx;
    logic         u_byte_done;
    logic         u_tx_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  edge_cnt   = 0;
    bit  model_busy = 1'b0;
    int  model_end  = 0;
    int  n_accept   = 0;

    // Scoreboard queues
    logic [7:0]   exp_bytes[$];
    logic [127:0] exp_words[$];
    int           exp_bdone[$];
    int           exp_tdone[$];
    int           done_edges[$];

    // Monitor decoder state
    logic         samp[0:FRAME-1];
    int           idx;
    bit           active;
    bit           ok;
    logic [7:0]   rx_byte;
    logic [127:0] rx_word;

    uart_tx_128 #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .start      (start),
        .busy       (busy),
        .u_tx       (u_tx),
        .u_byte_done(u_byte_done),
        .u_tx_done  (u_tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=none edge=%0d", name, what, edge_cnt);
    endtask

    // Reference model: on each edge decide acceptance from the spec rules and queue expectations.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                model_busy = 1'b0;
                exp_bytes.delete();
                exp_words.delete();
                exp_bdone.delete();
                exp_tdone.delete();
            end else if (!model_busy) begin
                if (start) begin
                    model_busy = 1'b1;
                    model_end  = edge_cnt + XFER;
                    n_accept++;
                    exp_words.push_back(data_in);
                    exp_tdone.push_back(model_end);
                    for (int k = 0; k < 16; k++) begin
                        exp_bytes.push_back(data_in[127-8*k -: 8]);
                        exp_bdone.push_back(edge_cnt + FRAME * (k + 1));
                    end
                    $display("accept #%0d edge=%0d word=%h", n_accept, edge_cnt, data_in);
                end
            end else if (edge_cnt == model_end) begin
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: decode the serial line and compare pulses against the scoreboard.
    initial begin
        active  = 1'b0;
        idx     = 0;
        rx_word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                check("busy", 128'(busy), 128'(model_busy));
                if (!model_busy) check("idle_line", 128'(u_tx), 128'(1));

                if (!active && (u_tx == 1'b0)) begin
                    active = 1'b1;
                    idx    = 0;
                end
                if (active) begin
                    samp[idx] = u_tx;
                    idx++;
                    if (idx == FRAME) begin
                        active = 1'b0;
                        ok     = 1'b1;
                        for (int j = 0; j < 10; j++)
                            for (int s = 1; s < CPB; s++)
                                if (samp[j*CPB+s] !== samp[j*CPB]) ok = 1'b0;
                        if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) ok = 1'b0;
                        for (int bi = 0; bi < 8; bi++) rx_byte[bi] = samp[(bi+1)*CPB];
                        check("frame_shape", 128'(ok), 128'(1));
                        rx_word = {rx_word[119:0], rx_byte};
                        if (exp_bytes.size() == 0) flag("unexpected_frame", "frame");
                        else begin
                            $display("frame edge=%0d byte=%h", edge_cnt, rx_byte);
                            check("frame_byte", 128'(rx_byte), 128'(exp_bytes.pop_front()));
                        end
                    end
                end

                if (u_byte_done) begin
                    if (exp_bdone.size() == 0) flag("byte_done", "pulse");
                    else check("byte_done_edge", 128'(edge_cnt), 128'(exp_bdone.pop_front()));
                end
                while (exp_bdone.size() > 0 && exp_bdone[0] < edge_cnt) begin
                    check("byte_done_missing", 128'(0), 128'(exp_bdone.pop_front()));
                end

                if (u_tx_done) begin
                    done_edges.push_back(edge_cnt);
                    if (exp_tdone.size() == 0) flag("tx_done", "pulse");
                    else begin
                        check("tx_done_edge", 128'(edge_cnt), 128'(exp_tdone.pop_front()));
                        $display("done edge=%0d loopback=%h", edge_cnt, rx_word);
                        check("loopback_word", rx_word, exp_words.pop_front());
                    end
                end
                while (exp_tdone.size() > 0 && exp_tdone[0] < edge_cnt) begin
                    check("tx_done_missing", 128'(0), 128'(exp_tdone.pop_front()));
                    if (exp_words.size() > 0) void'(exp_words.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int budget;
        budget = XFER + 20;
        tick(1);
        while (model_busy && budget > 0) begin
            tick(1);
            budget--;
        end
        if (model_busy) flag("wait_idle_timeout", "busy");
    endtask

    task automatic send(input logic [127:0] w);
        data_in = w;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        wait_idle();
    endtask

    // Called at a falling edge: assert reset between edges and check outputs at once.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_u_tx"}, 128'(u_tx), 128'(1));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_tx_done"}, 128'(u_tx_done), 128'(0));
        check({tag, "_byte_done"}, 128'(u_byte_done), 128'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stimulus sequence
    initial begin
        int base;
        int budget;
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_u_tx", 128'(u_tx), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_tx_done", 128'(u_tx_done), 128'(0));
        check("rst_byte_done", 128'(u_byte_done), 128'(0));
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single transfer
        send(128'h00112233_44556677_8899AABB_CCDDEEFF);
        tick(3);

        // Start and data changes while busy are ignored
        data_in = rand128();
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        tick(3 * FRAME + 10);
        data_in = '1;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        data_in = rand128();
        wait_idle();
        tick(2);

        // Loopback word
        send(128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C);
        tick(2);

        // Reset during frame 5, then a fresh full transfer
        data_in = rand128();
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        tick(5 * FRAME + 15);
        async_reset("midrst");
        tick(FRAME);
        send(rand128());
        tick(2);

        // Back-to-back with start held high
        base    = n_accept;
        data_in = rand128();
        start   = 1'b1;
        budget  = 0;
        while (n_accept < base + 2 && budget < 2 * XFER + 20) begin
            tick(1);
            budget++;
            if (n_accept == base + 1 && budget == 1) data_in = rand128();
        end
        if (n_accept < base + 2) flag("b2b_accept_timeout", "stalled");
        start = 1'b0;
        wait_idle();
        tick(2);
        if (done_edges.size() >= 2)
            check("b2b_gap", 128'(done_edges[done_edges.size()-1] - done_edges[done_edges.size()-2]), 128'(XFER + 1));
        else
            flag("b2b_gap", "missing_done");

        // Random transfers with random gaps
        for (int t = 0; t < 4; t++) begin
            tick($urandom_range(0, 5));
            send(rand128());
        end
        tick(5);

        check("pending_bytes", 128'(exp_bytes.size()), 128'(0));
        check("pending_byte_done", 128'(exp_bdone.size()), 128'(0));
        check("pending_tx_done", 128'(exp_tdone.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_128.md
# uart_tx_128

Transmit-side counterpart of the 128-bit UART receive path. Accepts a 128-bit word on a single-cycle start request, latches it, and serialises it as 16 back-to-back 8N1 UART frames on `u_tx`, most-significant byte first. Its `u_tx` output feeds the receive-side serial input, which shifts bytes in from the bottom. Because the most-significant byte is sent first, the receiver's 128-bit output equals this block's input after 16 frames.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- `clk` in 1: single system clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in 128: word to transmit; sampled only on an accepted start.
- `start` in 1: transfer request; accepted only when `busy` = 0.
- `busy` out 1: high while a 16-frame transfer is in progress.
- `u_tx` out 1: serial line; idle high.
- `u_byte_done` out 1: one-cycle pulse at the end of each frame's stop bit (16 per transfer).
- `u_tx_done` out 1: one-cycle pulse at the end of the 16th stop bit.

## Operation
- Reset values (async, immediate): `u_tx`=1, `busy`=0, `u_byte_done`=0, `u_tx_done`=0, all counters 0, state IDLE, shift register 0.
- Top FSM states:
  - IDLE → LOAD on `start`=1.
  - LOAD → SEND.
  - SEND → NEXT on a byte-done from the sub-module.
  - NEXT → SEND if `byte_cnt` < 15, else → DONE.
  - DONE → IDLE.
  - LOAD and NEXT are zero-length: folded into the same edge, no extra cycles.
- Accept edge: `data_in` is copied to a 128-bit shift register. Byte `[127:120]` goes to the byte transmitter and `byte_cnt` is set to 0.
- Each frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- After each stop bit the shift register shifts left by 8 and `byte_cnt` increments. The next byte's start bit follows immediately, with no idle gap.
- `start` while `busy` is ignored. `data_in` changes after acceptance have no effect.
- Byte counter is 4 bits and never wraps mid-transfer: count 15 terminates the transfer.
- Bit-period counter width is clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1 and then resets to 0.
- Reset mid-transfer aborts with no done pulse. The next `start` sends a full fresh 16-byte transfer.

## Timing
- `start` sampled high at edge N in IDLE: from edge N, `busy`=1 and `u_tx`=0 (start bit). `u_tx` is registered (glitch-free).
- Frame k (k = 0..15) occupies edges N+10·k·CPB to N+10·(k+1)·CPB.
- `u_byte_done` is asserted for the cycle following edge N+10·(k+1)·CPB.
- At edge N+160·CPB:
  - `u_tx_done`=1 and the final `u_byte_done`=1, both for one cycle.
  - `busy`=0 and `u_tx`=1.
- Total latency from start to done: 160·`CLKS_PER_BIT` cycles.
- `start` high in the `u_tx_done` cycle is accepted at the next edge. A permanently-high `start` therefore produces transfers separated by exactly one idle-high cycle.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_BITS`=8
  - `UART_FRAME_BITS`=10
  - `UART_WORD_BYTES`=16
  - `UART_DEFAULT_CLKS_PER_BIT`=868
  - byte-transmitter state enum (TX_IDLE, TX_START, TX_DATA, TX_STOP)
- Sub-module `uart_tx_byte`: single-frame 8N1 transmitter with `clk`, `rst`, `tx_start`, `tx_byte[7:0]`, `u_tx`, `tx_busy`, `tx_done`, parameter `CLKS_PER_BIT`. It is the sending twin of the existing byte receiver.
- Top level holds the 128-bit shift register, `byte_cnt`, the top FSM and the done pulses.

## Test plan
Unless stated, `CLKS_PER_BIT`=4.
- Reset: assert `rst` asynchronously between edges → same instant `u_tx`=1, `busy`=0, `u_tx_done`=0, `u_byte_done`=0.
- Single transfer: `data_in`=128'h00112233_44556677_8899AABB_CCDDEEFF, one-cycle `start` → line decodes bytes 00,11,…,FF in order, each frame exactly 40 cycles with correct start/stop bits. Expect 16 `u_byte_done` pulses and `u_tx_done` 640 cycles after the accept edge.
- Ignore while busy: pulse `start` with `data_in`=all-ones at frame 3 and change `data_in` → serial stream unchanged, still exactly 16 frames.
- Loopback: `u_tx` into the 128-bit receive path, `data_in`=128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C → receiver output equals `data_in` after the 16th frame.
- Reset mid-transfer: assert `rst` during frame 5 → `u_tx`=1 immediately and no `u_tx_done`. A new `start` sends all 16 bytes from byte `[127:120]`.
- Back-to-back: hold `start` high across two transfers → exactly one idle-high cycle between the last stop bit and the next start bit, two `u_tx_done` pulses 641 cycles apart.
